qam_mod_param: RTL



---
 rtl/qam_mod_param.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/qam_mod_param.sv
`timescale 1ns/1ps
// Parametrised QAM modulator: serial bits -> I/Q symbol -> LUT carrier -> I*cos + Q*sin.
// Optional macro QAM_GRAY_MAP_EN: treat each axis's bits as Gray code before level mapping.
module qam_mod_param #(
  parameter int BITS_PER_AXIS  = 2,
  parameter int SAMPLES        = 16,
  parameter int CYCLES_PER_SYM = 1,
  parameter int TRIG_W         = 12,
  parameter int OUT_W          = 16
) (
  input  logic                        inp_clk,
  input  logic                        rst_n,
  input  logic                        inputsignal,
  input  logic                        bit_valid,
  output logic                        bit_ready,
  output logic signed [TRIG_W-1:0]    sine,
  output logic signed [TRIG_W-1:0]    cosine,
  output logic [$clog2(SAMPLES)-1:0]  iter,
  output logic signed [OUT_W-1:0]     acos,
  output logic signed [OUT_W-1:0]     bsin,
  output logic signed [OUT_W:0]       qam_out,
  output logic                        out_valid,
  output logic                        initialize,
  output logic                        underrun,
  output logic                        o_dbg_state
);
  localparam int WB = 2 * BITS_PER_AXIS;
  localparam int LW = $clog2(SAMPLES);
  localparam int CW = $clog2(WB);
  localparam int PW = (CYCLES_PER_SYM > 1) ? $clog2(CYCLES_PER_SYM) : 1;
  localparam int AW = BITS_PER_AXIS + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Elaboration-time table entry, rounded half away from zero.
  function automatic logic signed [TRIG_W-1:0] lut_val(input int n, input bit use_cos);
    real ang;
    real x;
    int  v;
    ang = 2.0 * 3.14159265358979323846 * real'(n) / real'(SAMPLES);
    x   = real'((1 << (TRIG_W - 1)) - 1) * (use_cos ? $cos(ang) : $sin(ang));
    v   = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    return TRIG_W'(v);
  endfunction

  function automatic logic signed [AW-1:0] amp(input logic [BITS_PER_AXIS-1:0] bits);
    logic [BITS_PER_AXIS-1:0] k;
`ifdef QAM_GRAY_MAP_EN
    k[BITS_PER_AXIS-1] = bits[BITS_PER_AXIS-1];
    for (int i = BITS_PER_AXIS - 2; i >= 0; i--) k[i] = k[i+1] ^ bits[i];
`else
    k = bits;
`endif
    return AW'(2 * int'(k) - ((1 << BITS_PER_AXIS) - 1));
  endfunction

  logic signed [TRIG_W-1:0] w_sin_tab [SAMPLES];
  logic signed [TRIG_W-1:0] w_cos_tab [SAMPLES];

  for (genvar g = 0; g < SAMPLES; g++) begin : g_lut
    localparam logic signed [TRIG_W-1:0] SIN_V = lut_val(g, 1'b0);
    localparam logic signed [TRIG_W-1:0] COS_V = lut_val(g, 1'b1);
    assign w_sin_tab[g] = SIN_V;
    assign w_cos_tab[g] = COS_V;
  end

  state_t          r_state, w_state_nxt;
  logic [WB-2:0]   r_asm;
  logic [CW-1:0]   r_cnt;
  logic [WB-1:0]   r_hold, r_cur;
  logic            r_hold_full;
  logic [LW-1:0]   r_phase;
  logic [PW-1:0]   r_per;
  logic            r_und_pend;

  logic signed [TRIG_W-1:0] r_s1_sin, r_s1_cos;
  logic signed [AW-1:0]     r_s1_i, r_s1_q;
  logic [LW-1:0]            r_s1_iter;
  logic                     r_s1_valid, r_s1_init, r_s1_und;

  logic            w_accept, w_asm_done, w_bound, w_load_hold, w_bypass, w_underrun;
  logic [WB-1:0]   w_word;
  logic signed [OUT_W-1:0] w_acos, w_bsin;
  logic signed [OUT_W:0]   w_sum;

  // The only stall: a complete word would have nowhere to go.
  assign bit_ready   = !(r_hold_full && (r_cnt == CW'(WB - 1)));
  assign w_accept    = bit_valid && bit_ready;
  assign w_asm_done  = w_accept && (r_cnt == CW'(WB - 1));
  assign w_word      = {r_asm, inputsignal};
  assign w_bound     = (r_state == RUN) && (r_phase == LW'(SAMPLES - 1)) &&
                       (r_per == PW'(CYCLES_PER_SYM - 1));
  assign w_load_hold = r_hold_full && ((r_state == IDLE) || w_bound);
  assign w_bypass    = !r_hold_full && w_bound && w_asm_done;
  assign w_underrun  = w_bound && !r_hold_full && !w_asm_done;
  assign o_dbg_state = r_state;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (r_hold_full) w_state_nxt = RUN;
      RUN:  if (w_underrun)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge inp_clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge inp_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asm       <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_cur       <= '0;
      r_phase     <= '0;
      r_per       <= '0;
      r_und_pend  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_asm <= w_word[WB-2:0];
        r_cnt <= w_asm_done ? '0 : r_cnt + 1'b1;
      end
      if (w_load_hold) begin
        r_cur       <= r_hold;
        r_hold_full <= 1'b0;
      end else if (w_bypass) begin
        r_cur <= w_word;
      end else if (w_asm_done) begin
        r_hold      <= w_word;
        r_hold_full <= 1'b1;
      end
      if (r_state == RUN) begin
        r_phase <= r_phase + 1'b1;
        if (r_phase == LW'(SAMPLES - 1))
          r_per <= (r_per == PW'(CYCLES_PER_SYM - 1)) ? '0 : r_per + 1'b1;
      end else begin
        r_phase <= '0;
        r_per   <= '0;
      end
      r_und_pend <= w_underrun;
    end
  end

  // Stage 1: trig lookup and level mapping; everything zero outside RUN.
  always_ff @(posedge inp_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_sin <= '0; r_s1_cos <= '0; r_s1_i <= '0; r_s1_q <= '0;
      r_s1_iter <= '0; r_s1_valid <= 1'b0; r_s1_init <= 1'b0; r_s1_und <= 1'b0;
    end else begin
      r_s1_und <= r_und_pend;
      if (r_state == RUN) begin
        r_s1_sin   <= w_sin_tab[r_phase];
        r_s1_cos   <= w_cos_tab[r_phase];
        r_s1_i     <= amp(r_cur[WB-1:BITS_PER_AXIS]);
        r_s1_q     <= amp(r_cur[BITS_PER_AXIS-1:0]);
        r_s1_iter  <= r_phase;
        r_s1_valid <= 1'b1;
        r_s1_init  <= (r_phase == '0) && (r_per == '0);
      end else begin
        r_s1_sin <= '0; r_s1_cos <= '0; r_s1_i <= '0; r_s1_q <= '0;
        r_s1_iter <= '0; r_s1_valid <= 1'b0; r_s1_init <= 1'b0;
      end
    end
  end

  assign w_acos = OUT_W'(r_s1_i) * OUT_W'(r_s1_cos);
  assign w_bsin = OUT_W'(r_s1_q) * OUT_W'(r_s1_sin);
  assign w_sum  = (OUT_W+1)'(w_acos) + (OUT_W+1)'(w_bsin);

  // Stage 2: products and sum, with trig/iter re-registered to stay aligned.
  always_ff @(posedge inp_clk or negedge rst_n) begin
    if (!rst_n) begin
      sine <= '0; cosine <= '0; iter <= '0; acos <= '0; bsin <= '0; qam_out <= '0;
      out_valid <= 1'b0; initialize <= 1'b0; underrun <= 1'b0;
    end else begin
      sine       <= r_s1_sin;
      cosine     <= r_s1_cos;
      iter       <= r_s1_iter;
      acos       <= w_acos;
      bsin       <= w_bsin;
      qam_out    <= w_sum;
      out_valid  <= r_s1_valid;
      initialize <= r_s1_init;
      underrun   <= r_s1_und;
    end
  end
endmodule
